hist_equalizer: RTL and testbench

//  Consumer of the per-frame 256-bin gray histogram built upstream. After each frame's histogram

---
 rtl/hist_equalizer.sv | 215 +++++++++++++++++++++
 tb/tb_hist_equalizer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_equalizer.sv
// hist_equalizer: histogram-equalization remapper for the camera gray stream.
// After each hist_ready pulse it reads the 256-bin histogram, accumulates the
// CDF, scales it to 0..255 and writes the result into the shadow LUT bank.
// The new bank becomes active on the next vsync rising edge, which falls in
// blanking. Live pixels pass through the active bank with 2 cycles of latency.
// Optional build macro: HIST_EQ_BYPASS_EN adds input eq_bypass, which forwards
// cam_gray unchanged with the same latency.
module hist_equalizer #(
  parameter int unsigned PIX_TOTAL = 307200,
  parameter int unsigned RECIP     = 13927,
  parameter int unsigned SHIFT     = 24
) (
  input  logic        cam_clk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_valid,
  input  logic [7:0]  cam_gray,
`ifdef HIST_EQ_BYPASS_EN
  input  logic        eq_bypass,
`endif
  input  logic        hist_ready,
  output logic        hist_rd_en,
  output logic [7:0]  hist_rd_addr,
  input  logic [18:0] hist_rd_data,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [7:0]  post_img_Y,
  output logic        build_busy,
  output logic        lut_pending
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  if (PIX_TOTAL >= (32'd1 << 19)) begin : g_pix_total_chk
    $error("PIX_TOTAL must be below 2^19 to fit the 19-bit CDF");
  end

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        build_start;

  logic        v1_q, v2_q, v3_q;
  logic [7:0]  a1_q, a2_q, a3_q;
  logic [18:0] cdf_q;
  logic [32:0] prod_q;
  logic [32:0] scaled;
  logic [7:0]  lut_wr_val;

  logic [7:0]  lut0_q [256];
  logic [7:0]  lut1_q [256];
  logic        bank_sel_q;
  logic        pending_q;
  logic        vsync_rise;
  logic        swap;

  logic        bypass_in;
  logic [7:0]  gray_d1_q;
  logic        vsync_d1_q, href_d1_q, valid_d1_q, bypass_d1_q;
  logic        vsync_d2_q, href_d2_q, valid_d2_q;
  logic [7:0]  y_q;
  logic [7:0]  lut_rd;

`ifdef HIST_EQ_BYPASS_EN
  assign bypass_in = eq_bypass;
`else
  assign bypass_in = 1'b0;
`endif

  assign build_start  = (state_q == ST_IDLE) && hist_ready;
  assign hist_rd_en   = (state_q == ST_READ);
  assign hist_rd_addr = (state_q == ST_READ) ? cnt_q : '0;
  assign build_busy   = (state_q != ST_IDLE);
  assign lut_pending  = pending_q;

  // Build sequencer: READ walks all 256 bins, FLUSH drains the 3-stage pipe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hist_ready) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd255) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd2) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // CDF pipeline: accumulate, multiply by reciprocal, then saturate on write.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= '0;
      a2_q   <= '0;
      a3_q   <= '0;
      cdf_q  <= '0;
      prod_q <= '0;
    end else begin
      v1_q <= hist_rd_en;
      a1_q <= hist_rd_addr;
      v2_q <= v1_q;
      a2_q <= a1_q;
      v3_q <= v2_q;
      a3_q <= a2_q;
      if (build_start)
        cdf_q <= '0;
      else if (v1_q)
        cdf_q <= cdf_q + hist_rd_data;
      if (v2_q)
        prod_q <= 33'(cdf_q) * 33'(RECIP);
    end
  end

  assign scaled     = prod_q >> SHIFT;
  assign lut_wr_val = (|scaled[32:8]) ? 8'hFF : scaled[7:0];

  assign vsync_rise = cam_vsync && !vsync_d1_q;
  assign swap       = vsync_rise && pending_q && (state_q == ST_IDLE);

  // Bank control: pending set by DONE, swap only from IDLE on vsync rise.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      if (state_q == ST_DONE)
        pending_q <= 1'b1;
      else if (swap)
        pending_q <= 1'b0;
      if (swap)
        bank_sel_q <= !bank_sel_q;
    end
  end

  // LUT banks: identity after reset, only the inactive bank is ever written.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 256; k++) begin
        lut0_q[k[7:0]] <= k[7:0];
        lut1_q[k[7:0]] <= k[7:0];
      end
    end else if (v3_q) begin
      if (bank_sel_q)
        lut0_q[a3_q] <= lut_wr_val;
      else
        lut1_q[a3_q] <= lut_wr_val;
    end
  end

  assign lut_rd = bank_sel_q ? lut1_q[gray_d1_q] : lut0_q[gray_d1_q];

  // Pixel path: stage 1 captures inputs, stage 2 remaps and forwards syncs.
  always_ff @(posedge cam_clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_d1_q   <= '0;
      vsync_d1_q  <= 1'b0;
      href_d1_q   <= 1'b0;
      valid_d1_q  <= 1'b0;
      bypass_d1_q <= 1'b0;
      vsync_d2_q  <= 1'b0;
      href_d2_q   <= 1'b0;
      valid_d2_q  <= 1'b0;
      y_q         <= '0;
    end else begin
      gray_d1_q   <= cam_gray;
      vsync_d1_q  <= cam_vsync;
      href_d1_q   <= cam_href;
      valid_d1_q  <= cam_valid;
      bypass_d1_q <= bypass_in;
      vsync_d2_q  <= vsync_d1_q;
      href_d2_q   <= href_d1_q;
      valid_d2_q  <= valid_d1_q;
      if (valid_d1_q)
        y_q <= bypass_d1_q ? gray_d1_q : lut_rd;
      else
        y_q <= '0;
    end
  end

  assign post_frame_vsync = vsync_d2_q;
  assign post_frame_href  = href_d2_q;
  assign post_frame_clken = valid_d2_q;
  assign post_img_Y       = y_q;

endmodule

// File: tb/tb_hist_equalizer.sv
// Randomized self-checking bench for hist_equalizer. A behavioural histogram
// RAM answers reads; a reference LUT is computed directly from the CDF formula.
module tb_hist_equalizer;

  localparam longint RECIP = 13927;
  localparam int     SHIFT = 24;

  logic        cam_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_valid = 1'b0;
  logic [7:0]  cam_gray = '0;
`ifdef HIST_EQ_BYPASS_EN
  logic        eq_bypass = 1'b0;
`endif
  logic        hist_ready = 1'b0;
  logic        hist_rd_en;
  logic [7:0]  hist_rd_addr;
  logic [18:0] hist_rd_data = '0;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0]  post_img_Y;
  logic        build_busy, lut_pending;

  int unsigned hist_mem [256];
  int          act_lut [256];
  int          built_lut [256];
  int          busy_cnt = 0;
  int          rd_addrs [$];
  int          n_pass = 0;
  int          n_total = 0;

  hist_equalizer #(
    .PIX_TOTAL(307200),
    .RECIP(13927),
    .SHIFT(24)
  ) dut (
    .cam_clk(cam_clk),
    .rst_n(rst_n),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_valid(cam_valid),
    .cam_gray(cam_gray),
`ifdef HIST_EQ_BYPASS_EN
    .eq_bypass(eq_bypass),
`endif
    .hist_ready(hist_ready),
    .hist_rd_en(hist_rd_en),
    .hist_rd_addr(hist_rd_addr),
    .hist_rd_data(hist_rd_data),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken),
    .post_img_Y(post_img_Y),
    .build_busy(build_busy),
    .lut_pending(lut_pending)
  );

  always #5 cam_clk = ~cam_clk;

  // Histogram RAM: one-cycle read latency.
  always @(posedge cam_clk)
    hist_rd_data <= hist_rd_en ? 19'(hist_mem[hist_rd_addr]) : 19'd0;

  // Record read addresses and busy cycles.
  always @(negedge cam_clk) begin
    if (build_busy) busy_cnt++;
    if (hist_rd_en) rd_addrs.push_back(int'(hist_rd_addr));
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void model_build();
    longint cdf = 0;
    longint v;
    for (int k = 0; k < 256; k++) begin
      cdf += hist_mem[k];
      v = (cdf * RECIP) >> SHIFT;
      built_lut[k] = (v > 255) ? 255 : int'(v);
    end
  endfunction

  function automatic void identity_act();
    for (int k = 0; k < 256; k++) act_lut[k] = k;
  endfunction

  function automatic void fill_const(input int bin, input int unsigned val, input bit all);
    for (int k = 0; k < 256; k++) hist_mem[k] = all ? val : ((k == bin) ? val : 0);
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < 256; k++) hist_mem[k] = $urandom_range(0, 1200);
  endfunction

  task automatic pix(input int g, input int exp, input string tag);
    @(negedge cam_clk);
    cam_gray = 8'(g); cam_valid = 1'b1; cam_href = 1'b1;
    @(negedge cam_clk);
    cam_valid = 1'b0; cam_href = 1'b0;
    chk({tag, "_clken_early"}, post_frame_clken, 0);
    @(negedge cam_clk);
    chk({tag, "_clken"}, post_frame_clken, 1);
    chk({tag, "_href"}, post_frame_href, 1);
    chk({tag, "_Y"}, post_img_Y, exp);
  endtask

  task automatic rand_pix(input int n, input string tag);
    int g;
    repeat (n) begin
      g = $urandom_range(0, 255);
      pix(g, act_lut[g], tag);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (build_busy && n < 1000) begin
      @(negedge cam_clk);
      n++;
    end
    chk({tag, "_timeout"}, build_busy, 0);
  endtask

  task automatic do_build(input bit extra_ready, input string tag);
    int bad = 0;
    model_build();
    busy_cnt = 0;
    rd_addrs.delete();
    @(negedge cam_clk); hist_ready = 1'b1;
    @(negedge cam_clk); hist_ready = 1'b0;
    if (extra_ready) begin
      repeat (100) @(negedge cam_clk);
      hist_ready = 1'b1;
      @(negedge cam_clk); hist_ready = 1'b0;
    end
    wait_idle(tag);
    repeat (3) @(negedge cam_clk);
    for (int i = 0; i < rd_addrs.size(); i++) if (rd_addrs[i] != i) bad++;
    chk({tag, "_rd_count"}, rd_addrs.size(), 256);
    chk({tag, "_rd_contig"}, bad, 0);
    chk({tag, "_busy_cycles"}, busy_cnt, 260);
    chk({tag, "_pending"}, lut_pending, 1);
  endtask

  task automatic vsync_pulse();
    @(negedge cam_clk); cam_vsync = 1'b1;
    repeat (3) @(negedge cam_clk);
    chk("vsync_high_fwd", post_frame_vsync, 1);
    cam_vsync = 1'b0;
    repeat (3) @(negedge cam_clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    identity_act();
    repeat (3) @(negedge cam_clk);
    chk("rst_Y", post_img_Y, 0);
    chk("rst_clken", post_frame_clken, 0);
    chk("rst_vsync", post_frame_vsync, 0);
    chk("rst_busy", build_busy, 0);
    chk("rst_pending", lut_pending, 0);
    chk("rst_rd_en", hist_rd_en, 0);
    chk("rst_rd_addr", hist_rd_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge cam_clk);

    pix(37, 37, "identity37");
    rand_pix(4, "identity_rand");

    // Uniform histogram, with a second hist_ready while busy.
    fill_const(0, 1200, 1'b1);
    do_build(1'b1, "uniform");
    rand_pix(3, "uniform_preswap");
    vsync_pulse();
    chk("uniform_pending_clr", lut_pending, 0);
    act_lut = built_lut;
    pix(0, 0, "uniform_0");
    pix(127, 127, "uniform_127");
    pix(255, 255, "uniform_255");
    rand_pix(6, "uniform_rand");

    // All pixels in bin 100; active bank must stay untouched until the swap.
    fill_const(100, 307200, 1'b0);
    do_build(1'b0, "bin100");
    pix(100, act_lut[100], "bin100_preswap");
    vsync_pulse();
    act_lut = built_lut;
    pix(99, 0, "bin100_99");
    pix(100, 255, "bin100_100");
    pix(255, 255, "bin100_255");
`ifdef HIST_EQ_BYPASS_EN
    eq_bypass = 1'b1;
    pix(50, 50, "bypass_50");
    eq_bypass = 1'b0;
    pix(50, 0, "nobypass_50");
`endif

    // Vsync rise in the DONE cycle must not swap.
    fill_random();
    model_build();
    @(negedge cam_clk); hist_ready = 1'b1;
    @(negedge cam_clk); hist_ready = 1'b0;
    repeat (259) @(negedge cam_clk);
    chk("done_cycle_busy", build_busy, 1);
    cam_vsync = 1'b1;
    @(negedge cam_clk);
    chk("done_cycle_idle_next", build_busy, 0);
    repeat (2) @(negedge cam_clk);
    chk("done_edge_no_swap", lut_pending, 1);
    cam_vsync = 1'b0;
    repeat (2) @(negedge cam_clk);
    pix(99, act_lut[99], "done_old_99");
    rand_pix(3, "done_old_rand");
    vsync_pulse();
    chk("done_next_swap", lut_pending, 0);
    act_lut = built_lut;
    rand_pix(8, "done_new_rand");

    // Further random histograms.
    repeat (2) begin
      fill_random();
      do_build(1'b0, "random");
      vsync_pulse();
      act_lut = built_lut;
      rand_pix(8, "random_pix");
    end

    // Reset in the middle of the READ phase.
    fill_random();
    @(negedge cam_clk); hist_ready = 1'b1;
    @(negedge cam_clk); hist_ready = 1'b0;
    n = 0;
    while (!(hist_rd_en && hist_rd_addr == 8'd120) && n < 500) begin
      @(negedge cam_clk);
      n++;
    end
    chk("midrst_reach_120", hist_rd_addr, 120);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_en", hist_rd_en, 0);
    chk("midrst_busy", build_busy, 0);
    chk("midrst_pending", lut_pending, 0);
    chk("midrst_Y", post_img_Y, 0);
    repeat (2) @(negedge cam_clk);
    rst_n = 1'b1;
    identity_act();
    repeat (2) @(negedge cam_clk);
    pix(200, 200, "midrst_200");
    rand_pix(4, "midrst_identity");
    vsync_pulse();
    pix(99, 99, "midrst_no_swap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
